// File: rtl/alu.sv
// RV64 execute-stage ALU: combinational result/zero plus an enabled output
// register for the EX/MEM boundary.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [63:0] input1,
  input  logic [63:0] input2,
  input  logic [3:0]  alu_control,
  output logic [63:0] result,
  output logic        zero,
  output logic [63:0] result_q,
  output logic        zero_q
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1101
  } alu_op_e;

  logic [5:0] shamt;
  assign shamt = input2[5:0];

  always_comb begin
    result = '0;
    case (alu_control)
      OP_AND:  result = input1 & input2;
      OP_OR:   result = input1 | input2;
      OP_ADD:  result = input1 + input2;
      OP_XOR:  result = input1 ^ input2;
      OP_SLL:  result = input1 << shamt;
      OP_SRL:  result = input1 >> shamt;
      OP_SUB:  result = input1 - input2;
      OP_SLT:  result = {63'b0, $signed(input1) < $signed(input2)};
      OP_SLTU: result = {63'b0, input1 < input2};
      OP_SRA:  result = $signed(input1) >>> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (en) begin
      result_q <= result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: combinational ops, boundary cases,
// and output-register reset/enable behaviour.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [63:0] input1;
  logic [63:0] input2;
  logic [3:0]  alu_control;
  logic [63:0] result;
  logic        zero;
  logic [63:0] result_q;
  logic        zero_q;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  alu dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .input1     (input1),
    .input2     (input2),
    .alu_control(alu_control),
    .result     (result),
    .zero       (zero),
    .result_q   (result_q),
    .zero_q     (zero_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one operation mid-cycle and check result and zero after settling.
  task automatic vec(input string tag, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp);
    @(negedge clk);
    alu_control = op;
    input1      = a;
    input2      = b;
    #1;
    check({tag, ".res"}, result, exp);
    check({tag, ".zero"}, {63'b0, zero}, {63'b0, exp == 64'h0});
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    input1 = '0;
    input2 = '0;
    alu_control = 4'b0000;
    #1;
    check("rst.result_q", result_q, 64'h0);
    check("rst.zero_q", {63'b0, zero_q}, 64'h1);
    @(negedge clk);
    reset = 1'b0;

    vec("add",      4'b0010, 64'h10, 64'h20, 64'h30);
    vec("sub",      4'b0110, 64'h30, 64'h20, 64'h10);
    vec("and",      4'b0000, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'h0);
    vec("or",       4'b0001, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFFFFFFFFFF);
    vec("xor",      4'b0011, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'hFFFFFFFFFFFFFFFF);
    vec("slt",      4'b0111, 64'h10, 64'h20, 64'h1);
    vec("sltu_big", 4'b1000, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0);
    vec("slt_neg",  4'b0111, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h1);
    vec("sltu_sm",  4'b1000, 64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h1);
    vec("slt_eq",   4'b0111, 64'h5, 64'h5, 64'h0);
    vec("sll",      4'b0100, 64'h1, 64'h4, 64'h10);
    vec("srl",      4'b0101, 64'h10, 64'h2, 64'h4);
    vec("sra",      4'b1101, 64'h8000000000000000, 64'h4, 64'hF800000000000000);
    vec("sll_wrap", 4'b0100, 64'h1, 64'h41, 64'h2);
    vec("sra_64",   4'b1101, 64'h8000000000000000, 64'h40, 64'h8000000000000000);
    vec("srl_63",   4'b0101, 64'h8000000000000000, 64'h3F, 64'h1);
    vec("sra_pos",  4'b1101, 64'h4000000000000000, 64'h3E, 64'h1);
    vec("add_wrap", 4'b0010, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0);
    vec("sub_wrap", 4'b0110, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF);
    vec("undef_f",  4'b1111, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h0);
    vec("undef_9",  4'b1001, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h0);
    vec("undef_e",  4'b1110, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0);

    // en was low throughout, so the register still holds its reset value.
    check("hold_rst.result_q", result_q, 64'h0);

    // Capture a nonzero value, then assert reset between edges.
    vec("cap_add", 4'b0010, 64'h10, 64'h20, 64'h30);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("cap.result_q", result_q, 64'h30);
    check("cap.zero_q", {63'b0, zero_q}, 64'h0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.result_q", result_q, 64'h0);
    check("async_rst.zero_q", {63'b0, zero_q}, 64'h1);
    check("rst_comb.result", result, 64'h30);
    @(posedge clk);
    #1;
    check("rst_edge.result_q", result_q, 64'h0);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.result_q", result_q, 64'h30);
    check("post_rst.zero_q", {63'b0, zero_q}, 64'h0);

    @(negedge clk);
    en = 1'b0;
    alu_control = 4'b0110;
    input1 = 64'h100;
    input2 = 64'h1;
    @(posedge clk);
    #1;
    check("hold.result_q", result_q, 64'h30);
    check("hold.result", result, 64'hFF);

    @(negedge clk);
    en = 1'b1;
    alu_control = 4'b0000;
    input1 = 64'hF0;
    input2 = 64'h0F;
    @(posedge clk);
    #1;
    check("cap_zero.result_q", result_q, 64'h0);
    check("cap_zero.zero_q", {63'b0, zero_q}, 64'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

64-bit integer ALU for the RV64 datapath's execute stage. It computes arithmetic, logic, shift and compare results from two operands and a 4-bit operation code. Result and zero flag are available combinationally in the same cycle. A registered copy of both is also provided for the EX/MEM boundary.

## Interface
- No parameters; data width fixed at 64.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock, used only by the output register.
- reset  in  1  asynchronous, active-high; clears the output register.
- en  in  1  capture enable for the output register.
- input1  in  64  operand A (rs1).
- input2  in  64  operand B (rs2 or immediate); shift amount taken from bits [5:0].
- alu_control  in  4  operation select.
- result  out  64  combinational result.
- zero  out  1  combinational; 1 when result == 0.
- result_q  out  64  registered result.
- zero_q  out  1  registered zero.

## Operation
Operation codes for alu_control:
- 0000 AND: input1 & input2.
- 0001 OR: input1 | input2.
- 0010 ADD: input1 + input2, modulo 2^64. Carry is discarded; no overflow flag.
- 0011 XOR: input1 ^ input2.
- 0100 SLL: input1 << input2[5:0], zero fill.
- 0101 SRL: input1 >> input2[5:0], zero fill.
- 0110 SUB: input1 - input2, modulo 2^64.
- 0111 SLT: 1 if input1 < input2 as signed two's complement, else 0. Zero-extended to 64 bits.
- 1000 SLTU: 1 if input1 < input2 as unsigned, else 0. Zero-extended to 64 bits.
- 1101 SRA: signed input1 >>> input2[5:0], filling with input1[63].
- All other codes (1001–1100, 1110, 1111): result = 0, so zero = 1.

Rules that apply to all operations:
- Shift amounts use only input2[5:0]. Bits [63:6] are ignored, so a shift by 64 behaves as a shift by 0.
- zero = (result == 64'h0) for every code, including the compares and undefined codes.
- No internal state exists other than the output register.

## Timing
- result and zero are purely combinational: zero cycles of latency, settling within the same cycle as any input change.
- On the rising edge of clk with en = 1: result_q ← result and zero_q ← zero.
- With en = 0 the register holds its value.
- reset = 1 forces result_q = 0 and zero_q = 1 immediately, without waiting for a clock edge, and holds them while asserted.
- After reset deasserts, the first capture happens at the next rising edge with en = 1.
- If reset and a clock edge coincide, reset wins.
- Reset has no effect on the combinational outputs.
- The whole path must close within one clock period.

## Test plan
- ADD 0x10 + 0x20 → result 0x30, zero 0. SUB 0x30 − 0x20 → 0x10, zero 0.
- AND 0xF0F0F0F0F0F0F0F0 & 0x0F0F0F0F0F0F0F0F → 0, zero 1. OR of the same operands → 0xFFFFFFFFFFFFFFFF. XOR 0xAAAA…AAAA ^ 0x5555…5555 → 0xFFFFFFFFFFFFFFFF.
- Compares:
  - SLT 0x10 vs 0x20 → 1.
  - SLTU 0xFFFFFFFFFFFFFFFF vs 0x1 → 0, zero 1.
  - SLT 0xFFFFFFFFFFFFFFFF vs 0x1 → 1.
- Shifts:
  - SLL 0x1 by 4 → 0x10.
  - SRL 0x10 by 2 → 0x4.
  - SRA 0x8000000000000000 by 4 → 0xF800000000000000.
  - SLL 0x1 with input2 = 0x41 → 0x2, since only the low 6 bits count.
- Undefined code 1111 with input1 = 0x123456789ABCDEF0, input2 = 0x0FEDCBA987654321 → result 0, zero 1.
- Register behaviour:
  - Assert reset mid-cycle → result_q = 0 and zero_q = 1 without a clock edge.
  - Release reset, ADD 0x10 + 0x20 with en = 1 → result_q = 0x30 after one edge.
  - Drop en and change inputs → result_q holds 0x30.
